// File: rtl/xylo_player_if.sv
// Control and display bundle for the xylophone note player.
// The bench drives the master side; the player sits on the slave side.
interface xylo_player_if #(
   parameter int DUR_W = 8
);
   logic [3:0]       note_in;
   logic [DUR_W-1:0] dur_in;
   logic             push;
   logic             play;
   logic             stop;
   logic             s0, s1, s2, s3, s4, s5, s6;
   logic [3:0]       note_out;
   logic             busy;
   logic             full;
   logic             empty;
   logic             done;
   logic             overflow;

   modport master (
      output note_in, dur_in, push, play, stop,
      input  s0, s1, s2, s3, s4, s5, s6, note_out, busy, full, empty, done, overflow
   );

   modport slave (
      input  note_in, dur_in, push, play, stop,
      output s0, s1, s2, s3, s4, s5, s6, note_out, busy, full, empty, done, overflow
   );
endinterface

// File: rtl/xylo_player.sv
// Queued note player: a FIFO of {note, duration} entries played one by one
// on a seven-segment display, with a one-cycle blank gap between notes.
module xylo_player #(
   parameter int DEPTH = 8,
   parameter int DUR_W = 8
) (
   input logic          clock,
   input logic          reset,
   xylo_player_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t           state;
   logic [3:0]       mem_note [DEPTH];
   logic [DUR_W-1:0] mem_dur  [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [DUR_W-1:0] dur_cnt;
   logic [6:0]       seg;
   logic [3:0]       note_q;
   logic             done_q;
   logic             overflow_q;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;
   logic [3:0]       head_note;
   logic [DUR_W-1:0] head_dur;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'h3F;
         4'h1: p = 7'h06;
         4'h2: p = 7'h5B;
         4'h3: p = 7'h4F;
         4'h4: p = 7'h66;
         4'h5: p = 7'h6D;
         4'h6: p = 7'h7D;
         4'h7: p = 7'h07;
         4'h8: p = 7'h7F;
         4'h9: p = 7'h6F;
         4'hA: p = 7'h77;
         4'hB: p = 7'h7C;
         4'hC: p = 7'h39;
         4'hD: p = 7'h5E;
         4'hE: p = 7'h79;
         default: p = 7'h71;
      endcase
      return p;
   endfunction

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A pop happens exactly on the cycle the FSM commits to entering PLAY,
   // so the pushed-while-full case can still succeed in that same cycle.
   always_comb begin
      do_pop    = 1'b0;
      do_push   = 1'b0;
      head_note = mem_note[rd_ptr];
      head_dur  = mem_dur[rd_ptr];
      if (!bus.stop && !empty) begin
         do_pop = ((state == IDLE) && bus.play) || (state == GAP);
      end
      do_push = bus.push && (!full || do_pop);
   end

   always_ff @(posedge clock) begin
      if (do_push && !reset) begin
         mem_note[wr_ptr] <= bus.note_in;
         mem_dur[wr_ptr]  <= bus.dur_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (bus.push && full && !do_pop) overflow_q <= 1'b1;
      end
   end

   // dur_cnt holds the PLAY cycles still to come after the current one;
   // a zero duration is stretched to a single cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         seg     <= '0;
         note_q  <= '0;
         dur_cnt <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            state  <= IDLE;
            seg    <= '0;
            note_q <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (do_pop) begin
                     state   <= PLAY;
                     seg     <= seg_of(head_note);
                     note_q  <= head_note;
                     dur_cnt <= (head_dur == '0) ? '0 : head_dur - DUR_W'(1);
                  end
               end
               PLAY: begin
                  if (dur_cnt == '0) begin
                     state  <= GAP;
                     seg    <= '0;
                     note_q <= '0;
                  end else begin
                     dur_cnt <= dur_cnt - DUR_W'(1);
                  end
               end
               GAP: begin
                  if (do_pop) begin
                     state   <= PLAY;
                     seg     <= seg_of(head_note);
                     note_q  <= head_note;
                     dur_cnt <= (head_dur == '0) ? '0 : head_dur - DUR_W'(1);
                  end else begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  seg    <= '0;
                  note_q <= '0;
               end
            endcase
         end
      end
   end

   assign bus.s0       = seg[0];
   assign bus.s1       = seg[1];
   assign bus.s2       = seg[2];
   assign bus.s3       = seg[3];
   assign bus.s4       = seg[4];
   assign bus.s5       = seg[5];
   assign bus.s6       = seg[6];
   assign bus.note_out = note_q;
   assign bus.busy     = (state != IDLE);
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.done     = done_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_xylo_player.sv
// Directed bench for xylo_player: hand-computed segment sequences, FIFO
// limits, stop and reset behaviour.
module tb_xylo_player;
   localparam int DEPTH = 8;
   localparam int DUR_W = 8;

   logic       clock;
   logic       reset;
   logic [6:0] segs;
   int         checks;
   int         passes;

   logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   xylo_player_if #(.DUR_W(DUR_W)) bus_if ();

   xylo_player #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   assign segs = {bus_if.s6, bus_if.s5, bus_if.s4, bus_if.s3, bus_if.s2, bus_if.s1, bus_if.s0};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      else             passes++;
   endtask

   // Drive one cycle of inputs, let the edge happen, then return inputs to rest.
   task automatic applyStimulus(input logic do_push, input logic do_play, input logic do_stop,
                                input logic [3:0] note, input logic [DUR_W-1:0] dur);
      bus_if.push    = do_push;
      bus_if.play    = do_play;
      bus_if.stop    = do_stop;
      bus_if.note_in = note;
      bus_if.dur_in  = dur;
      tick();
      bus_if.push = 1'b0;
      bus_if.play = 1'b0;
      bus_if.stop = 1'b0;
   endtask

   // Called while the first PLAY cycle of a note is visible: checks every
   // sounding cycle, then the blank gap, and leaves us past the gap edge.
   task automatic checkNote(input logic [3:0] code, input int cycles);
      for (int d = 0; d < cycles; d++) begin
         checkOutput($sformatf("seg_%0h_c%0d", code, d), {25'd0, segs}, {25'd0, seg_table[code]});
         checkOutput($sformatf("note_%0h", code), {28'd0, bus_if.note_out}, {28'd0, code});
         tick();
      end
      checkOutput($sformatf("gap_blank_%0h", code), {25'd0, segs}, 32'd0);
      checkOutput($sformatf("gap_busy_%0h", code), {31'd0, bus_if.busy}, 32'd1);
      tick();
   endtask

   task automatic checkDone();
      checkOutput("done_pulse", {31'd0, bus_if.done}, 32'd1);
      checkOutput("idle_busy", {31'd0, bus_if.busy}, 32'd0);
      checkOutput("idle_blank", {25'd0, segs}, 32'd0);
      tick();
      checkOutput("done_single", {31'd0, bus_if.done}, 32'd0);
   endtask

   task automatic checkResetState();
      checkOutput("rst_segs", {25'd0, segs}, 32'd0);
      checkOutput("rst_note", {28'd0, bus_if.note_out}, 32'd0);
      checkOutput("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      checkOutput("rst_full", {31'd0, bus_if.full}, 32'd0);
      checkOutput("rst_empty", {31'd0, bus_if.empty}, 32'd1);
      checkOutput("rst_done", {31'd0, bus_if.done}, 32'd0);
      checkOutput("rst_ovf", {31'd0, bus_if.overflow}, 32'd0);
   endtask

   initial begin
      checks         = 0;
      passes         = 0;
      reset          = 1'b1;
      bus_if.push    = 1'b0;
      bus_if.play    = 1'b0;
      bus_if.stop    = 1'b0;
      bus_if.note_in = '0;
      bus_if.dur_in  = '0;
      tick();
      reset = 1'b0;
      checkResetState();

      $display("[TB] two-note sequence");
      applyStimulus(1, 0, 0, 4'h3, 8'd2);
      applyStimulus(1, 0, 0, 4'h5, 8'd1);
      checkOutput("two_not_empty", {31'd0, bus_if.empty}, 32'd0);
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      checkOutput("two_busy", {31'd0, bus_if.busy}, 32'd1);
      checkNote(4'h3, 2);
      checkNote(4'h5, 1);
      checkDone();

      $display("[TB] zero duration");
      applyStimulus(1, 0, 0, 4'hA, 8'd0);
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      checkNote(4'hA, 1);
      checkDone();

      $display("[TB] fill, push with pop at full");
      for (int i = 0; i < DEPTH; i++) begin
         checkOutput("fill_not_full", {31'd0, bus_if.full}, 32'd0);
         applyStimulus(1, 0, 0, 4'(i), 8'd1);
      end
      checkOutput("fill_full", {31'd0, bus_if.full}, 32'd1);
      checkOutput("fill_no_ovf", {31'd0, bus_if.overflow}, 32'd0);
      applyStimulus(1, 1, 0, 4'h9, 8'd1);
      checkOutput("pushpop_full", {31'd0, bus_if.full}, 32'd1);
      checkOutput("pushpop_no_ovf", {31'd0, bus_if.overflow}, 32'd0);
      for (int i = 0; i < DEPTH; i++) checkNote(4'(i), 1);
      checkNote(4'h9, 1);
      checkDone();

      $display("[TB] overflow");
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 4'(8 + i), 8'd1);
      checkOutput("ovf_full", {31'd0, bus_if.full}, 32'd1);
      checkOutput("ovf_before", {31'd0, bus_if.overflow}, 32'd0);
      applyStimulus(1, 0, 0, 4'h1, 8'd1);
      checkOutput("ovf_set", {31'd0, bus_if.overflow}, 32'd1);
      checkOutput("ovf_still_full", {31'd0, bus_if.full}, 32'd1);
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      for (int i = 0; i < DEPTH; i++) checkNote(4'(8 + i), 1);
      checkDone();
      checkOutput("ovf_sticky", {31'd0, bus_if.overflow}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkResetState();

      $display("[TB] stop mid-note");
      applyStimulus(1, 0, 0, 4'h1, 8'd4);
      applyStimulus(1, 0, 0, 4'h2, 8'd4);
      applyStimulus(1, 0, 0, 4'h3, 8'd4);
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      checkOutput("stop_first_seg", {25'd0, segs}, {25'd0, seg_table[1]});
      tick();
      applyStimulus(0, 0, 1, 4'h0, 8'd0);
      checkOutput("stop_busy", {31'd0, bus_if.busy}, 32'd0);
      checkOutput("stop_blank", {25'd0, segs}, 32'd0);
      checkOutput("stop_note", {28'd0, bus_if.note_out}, 32'd0);
      checkOutput("stop_no_done", {31'd0, bus_if.done}, 32'd0);
      tick();
      checkOutput("stop_no_done2", {31'd0, bus_if.done}, 32'd0);
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      checkNote(4'h2, 4);
      checkNote(4'h3, 4);
      checkDone();

      $display("[TB] push during final gap");
      applyStimulus(1, 0, 0, 4'h4, 8'd1);
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      checkOutput("late_seg", {25'd0, segs}, {25'd0, seg_table[4]});
      tick();
      applyStimulus(1, 0, 0, 4'h6, 8'd1);
      checkOutput("late_done", {31'd0, bus_if.done}, 32'd1);
      checkOutput("late_idle", {31'd0, bus_if.busy}, 32'd0);
      checkOutput("late_not_empty", {31'd0, bus_if.empty}, 32'd0);
      applyStimulus(0, 1, 1, 4'h0, 8'd0);
      checkOutput("stop_beats_play", {31'd0, bus_if.busy}, 32'd0);
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      checkNote(4'h6, 1);
      checkDone();

      $display("[TB] reset mid-playback");
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 4'(i + 7), 8'd4);
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      checkOutput("pre_rst_seg", {25'd0, segs}, {25'd0, seg_table[7]});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkResetState();
      applyStimulus(0, 1, 0, 4'h0, 8'd0);
      checkOutput("play_empty_ignored", {31'd0, bus_if.busy}, 32'd0);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/xylo_player.md
XYLO_PLAYER -- requirements
Module: xylo_player

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: note FIFO depth, a power of two, 2 to 64.
REQ-002 The block SHALL have parameter DUR_W, default 8: width of the note-duration field.
REQ-003 The block SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port note_in  input  4  note code to enqueue.
REQ-006 The block SHALL have port dur_in  input  DUR_W  hold time in cycles, enqueued together with note_in.
REQ-007 The block SHALL have port push  input  1  enqueue {note_in, dur_in} this cycle.
REQ-008 The block SHALL have port play  input  1  start playback from IDLE.
REQ-009 The block SHALL have port stop  input  1  abort playback.
REQ-010 The block SHALL have ports s0..s6  output  1 each  segments a..g, active-high, blank = all 0.
REQ-011 The block SHALL have port note_out  output  4  code of the note currently sounding; 0 when not in PLAY.
REQ-012 The block SHALL have ports busy, full, empty, done, overflow  output  1 each  status flags.

Function
REQ-013 The FIFO SHALL hold up to DEPTH entries of {note, dur}, with full = (count==DEPTH) and empty = (count==0).
REQ-014 A push while full and not popping in the same cycle SHALL be dropped and SHALL set sticky overflow; a push and a pop in the same cycle SHALL both take effect, at any count.
REQ-015 The FSM SHALL have states IDLE, PLAY and GAP, and busy SHALL equal (state != IDLE).
REQ-016 IDLE SHALL move to PLAY when play=1, stop=0 and empty=0; play with empty=1 SHALL be ignored.
REQ-017 On each entry to PLAY the head entry SHALL be popped, and its dur SHALL be latched as D = max(dur,1).
REQ-018 PLAY SHALL last exactly D cycles, then move to GAP.
REQ-019 GAP SHALL last exactly 1 cycle with segments blank, then move to PLAY (popping the next entry) if empty=0, else to IDLE.
REQ-020 done SHALL pulse for exactly 1 cycle, on the cycle after GAP when the block returns to IDLE because the FIFO drained.
REQ-021 stop SHALL have priority over play and over every transition.
REQ-022 stop in PLAY or GAP SHALL move the block to IDLE next cycle, discard the sounding note, keep the remaining FIFO contents and produce no done pulse.
REQ-023 Segments SHALL be registered, valid in the same cycle as state PLAY, and blank in IDLE and GAP.
REQ-024 Segment patterns {s6..s0} per note code SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
REQ-025 A push into an empty FIFO during GAP SHALL be seen by the GAP decision only from the cycle after the push.

Reset
REQ-026 reset=1 SHALL take priority over all inputs and SHALL force state IDLE, FIFO count 0, s0..s6=0, note_out=0, busy=0, full=0, empty=1, done=0 and overflow=0 on the next edge.
REQ-027 reset asserted mid-playback SHALL discard all queued notes.

Verification
REQ-028 The bench SHALL push {3,dur 2}, {5,dur 1} and then pulse play, and SHALL see segments 4F for 2 cycles, blank for 1, 6D for 1, blank for 1, then IDLE with done=1 for one cycle.
REQ-029 The bench SHALL push {A,dur 0} and play, and SHALL see 77 held for exactly 1 cycle (dur 0 treated as 1).
REQ-030 The bench SHALL push DEPTH+1 entries, and SHALL see full=1 after DEPTH pushes, overflow=1 after the last push and count held at DEPTH.
REQ-031 The bench SHALL push 3 notes with dur 4, play, and assert stop in the 2nd PLAY cycle, and SHALL see IDLE next cycle, blank segments, count=2 and done=0.
REQ-032 The bench SHALL assert reset during PLAY with 4 entries queued, and SHALL see all outputs at reset values and empty=1 on the next edge.
REQ-033 The bench SHALL play note codes 0..F with dur 1 each, and SHALL check every segment pattern against REQ-024.
